obi_rr_mux: RTL

OBI_RR_MUX -- requirements
Module: obi_rr_mux

---
 rtl/obi_rr_mux.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/obi_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module   : obi_rr_mux (with obi_rr_mux_pkg)
//  Purpose  : Merges NMASTER OBI master ports onto one OBI slave port.
//             Arbitration is round-robin (RR_EN=1) or fixed lowest-index
//             priority (RR_EN=0). An in-order ID FIFO routes each rvalid back
//             to the master whose address phase was granted first.
//  Ports    : clk_i          - clock, rising edge
//             rst_ni         - synchronous active-low reset
//             master_req_i   - NMASTER upstream requests
//             master_resp_o  - NMASTER upstream responses (gnt/rvalid/rdata)
//             slave_req_o    - merged downstream request
//             slave_resp_i   - downstream response
//             outstanding_o  - granted transactions still awaiting rvalid
//             err_o          - sticky: rvalid seen with nothing outstanding
//  Revision : 1.0 - initial release
// ============================================================================
package obi_rr_mux_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_rr_mux
    import obi_rr_mux_pkg::*;
#(
    parameter int NMASTER         = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RR_EN           = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  obi_req_t  [NMASTER-1:0]               master_req_i,
    output obi_resp_t [NMASTER-1:0]               master_resp_o,
    output obi_req_t                              slave_req_o,
    input  obi_resp_t                             slave_resp_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  err_o
);

    localparam int IDX_W = $clog2(NMASTER);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NMASTER - 1);

    // State
    logic [IDX_W-1:0] r_ptr;
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    // Combinational
    logic             w_any_req;
    logic             w_full;
    logic [IDX_W-1:0] w_arb_sel;
    logic [IDX_W-1:0] w_sel;
    logic             w_req;
    logic             w_hs;
    logic             w_pop;
    logic [IDX_W-1:0] w_head;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;

    always_comb begin
        w_any_req = 1'b0;
        for (int i = 0; i < NMASTER; i++) begin
            w_any_req = w_any_req | master_req_i[i].req;
        end
    end

    generate
        if (RR_EN != 0) begin : g_rr
            int   w_idx;
            logic w_found;
            // First requester at or after r_ptr, searching upward with wrap.
            always_comb begin
                w_arb_sel = r_ptr;
                w_found   = 1'b0;
                w_idx     = 0;
                for (int k = 0; k < NMASTER; k++) begin
                    w_idx = int'(r_ptr) + k;
                    if (w_idx >= NMASTER) begin
                        w_idx = w_idx - NMASTER;
                    end
                    if (!w_found && master_req_i[w_idx].req) begin
                        w_arb_sel = IDX_W'(w_idx);
                        w_found   = 1'b1;
                    end
                end
            end
        end else begin : g_fixed
            // Scan downward so the lowest requesting index is written last.
            always_comb begin
                w_arb_sel = '0;
                for (int k = NMASTER - 1; k >= 0; k--) begin
                    if (master_req_i[k].req) begin
                        w_arb_sel = IDX_W'(k);
                    end
                end
            end
        end
    endgenerate

    // A stalled address phase must stay on the same master until granted.
    assign w_sel      = r_lock ? r_lock_idx : w_arb_sel;
    assign w_full     = (r_count == c_cnt_max);
    assign w_req      = w_any_req & ~w_full;
    assign w_hs       = w_req & slave_resp_i.gnt;
    assign w_pop      = slave_resp_i.rvalid & (r_count != '0);
    assign w_head     = r_fifo[r_rptr];
    assign w_wptr_nxt = (r_wptr == c_ptr_last) ? '0 : r_wptr + PTR_W'(1);
    assign w_rptr_nxt = (r_rptr == c_ptr_last) ? '0 : r_rptr + PTR_W'(1);

    always_comb begin
        slave_req_o = '0;
        if (w_req) begin
            slave_req_o     = master_req_i[w_sel];
            slave_req_o.req = 1'b1;
        end
    end

    always_comb begin
        master_resp_o = '0;
        for (int i = 0; i < NMASTER; i++) begin
            master_resp_o[i].gnt = slave_resp_i.gnt & w_req & (w_sel == IDX_W'(i));
            if (w_pop && (w_head == IDX_W'(i))) begin
                master_resp_o[i].rvalid = 1'b1;
                master_resp_o[i].rdata  = slave_resp_i.rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                r_fifo[k] <= '0;
            end
        end else begin
            if (w_hs) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= w_wptr_nxt;
                r_lock         <= 1'b0;
                if (RR_EN != 0) begin
                    r_ptr <= (w_sel == c_idx_last) ? '0 : w_sel + IDX_W'(1);
                end
            end else if (w_req) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end

            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end

            if (w_hs && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (slave_resp_i.rvalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign outstanding_o = r_count;
    assign err_o         = r_err;

endmodule
`default_nettype wire
